// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with a configurable number of data-phase wait states.
//
// Storage is MEM_WORDS x 32-bit words with little-endian byte lanes. Every
// accepted transfer is a single beat. Illegal transfers get the two-cycle
// ERROR response: a size wider than a word, a misaligned address, or a word
// index past the end of memory.
//
// Ports:
//   HCLK, HRESET         clock and asynchronous active-high reset
//   HSEL                 slave select from the address decoder
//   HADDR .. HWDATA      AHB-Lite master signals (HBURST/HPROT/HMASTLOCK ignored)
//   HREADY               bus-level ready, qualifies address phases
//   HREADYOUT, HRESP     data-phase ready and response (1 = ERROR)
//   HRDATA               read data; zero outside a read's final data cycle
module ahb_sram_slave #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned IdxW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0]  WaitInit = 3'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;

  logic [31:0] mem [MEM_WORDS];

  logic            can_accept;
  logic            accept;
  logic            req_err;
  logic [IdxW-1:0] idx;
  logic [3:0]      strb;

  // A new address phase is only taken while no data phase of ours is stalling the bus.
  assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
  assign idx        = addr_q[IdxW+1:2];

  always_comb begin
    req_err = 1'b0;
    unique case (HSIZE)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = HADDR[0];
      3'b010:  req_err = |HADDR[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, HADDR[31:2]} >= MEM_WORDS) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q <= 3'd1) begin
          state_d = StData;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    // An accept in DATA or ERR2 overrides the return to IDLE: back-to-back beats.
    if (accept) begin
      addr_d  = HADDR;
      write_d = HWRITE;
      size_d  = HSIZE;
      if (req_err) begin
        state_d = StErr1;
      end else if (WAIT_STATES == 0) begin
        state_d = StData;
      end else begin
        state_d = StWait;
        cnt_d   = WaitInit;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Byte-lane enables for the registered transfer.
  always_comb begin
    strb = 4'b1111;
    unique case (size_q)
      3'b000:  strb = 4'b0001 << addr_q[1:0];
      3'b001:  strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Memory is not reset; a reset forces IDLE, so an interrupted write never commits.
  always_ff @(posedge HCLK) begin
    if ((state_q == StData) && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) begin
          mem[idx][8*k +: 8] <= HWDATA[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;
    unique case (state_q)
      StWait: HREADYOUT = 1'b0;
      StData: begin
        if (!write_q) begin
          HRDATA = mem[idx];
        end
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2:  HRESP = 1'b1;
      default: ;
    endcase
  end

  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q};

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the data-phase wait cycles per OKAY transfer (0..7).
REQ-003 SHALL have port HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port HSEL  input  1  slave select from the decoder.
REQ-006 SHALL have ports HADDR in 32, HWRITE in 1, HSIZE in 3, HBURST in 3, HPROT in 4, HTRANS in 2, HMASTLOCK in 1, HWDATA in 32; standard AHB-Lite master signals.
REQ-007 SHALL have port HREADY  input  1  bus-level ready (end of the previous data phase).
REQ-008 SHALL have port HREADYOUT  output  1  this slave's data-phase ready.
REQ-009 SHALL have port HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-010 SHALL have port HRDATA  output  32  read data.

Function
REQ-011 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ); it SHALL register HADDR, HWRITE and HSIZE at that edge.
REQ-012 SHALL answer IDLE/BUSY or unselected address phases with a zero-wait OKAY (HREADYOUT=1, HRESP=0) and no memory side effect.
REQ-013 SHALL implement states IDLE, WAIT, DATA, ERR1, ERR2. IDLE->WAIT on accept when WAIT_STATES>0 and no error; IDLE->DATA when WAIT_STATES=0 and no error; IDLE->ERR1 on an accepted error.
REQ-014 WAIT SHALL drive HREADYOUT=0 and HRESP=0, and SHALL count down for exactly WAIT_STATES cycles before moving to DATA.
REQ-015 DATA SHALL drive HREADYOUT=1 and HRESP=0 for one cycle; a new transfer accepted in that cycle SHALL be handled back-to-back with no idle cycle; otherwise the state returns to IDLE.
REQ-016 An error SHALL be HSIZE>3'b010, a misaligned address (halfword with HADDR[0]=1, word with HADDR[1:0]!=0), or HADDR[31:2]>=MEM_WORDS.
REQ-017 Error response: ERR1 SHALL drive HREADYOUT=0 and HRESP=1; ERR2 SHALL drive HREADYOUT=1 and HRESP=1; error takes precedence over WAIT_STATES; no memory write occurs.
REQ-018 Writes SHALL commit at the end of the DATA cycle, using HWDATA sampled in that cycle. Byte lanes are little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  Untouched lanes SHALL keep their value.
REQ-019 Reads SHALL drive the full 32-bit word mem[addr_q[31:2]] on HRDATA during the DATA cycle; HRDATA SHALL be 0 in all other cycles.
REQ-020 A read whose address phase overlaps a write's DATA cycle to the same word SHALL return the newly written data.
REQ-021 HBURST, HPROT and HMASTLOCK SHALL be accepted and ignored; bursts are handled as independent single beats.
REQ-022 A BUSY received during WAIT SHALL NOT alter the in-progress transfer.

Reset
REQ-023 While HRESET=1, outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0, and state SHALL be IDLE with the wait counter 0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-transfer SHALL abort it with no write committed; the first transfer after deassertion SHALL behave normally.

Verification
REQ-026 Write-then-read, WAIT_STATES=1: write word 0x0000_0010 = 0xDEADBEEF, then read 0x10. Required: one HREADYOUT=0 cycle per transfer; read returns 0xDEADBEEF with HRESP=0.
REQ-027 Byte write, word preset 0x11223344: byte write 0xAA to address 0x13. Required: word read returns 0xAA223344.
REQ-028 Misaligned access: word write at 0x0000_0002. Required: HREADYOUT 0 then 1 with HRESP=1 in both cycles; a later read of 0x00 is unchanged.
REQ-029 Out of range, MEM_WORDS=256: read at 0x0000_0400. Required: two-cycle ERROR; HRDATA=0.
REQ-030 Back-to-back, WAIT_STATES=0: four SEQ word writes at 0x20..0x2C followed by four reads. Required: HREADYOUT stays 1 throughout; data matches.
REQ-031 Reset mid-transfer: assert HRESET during WAIT of a write of 0x5555AAAA to 0x40. Required: outputs return to reset values immediately; 0x40 keeps its old value.
